handshake_rr_arbiter: RTL and testbench

- Shares one single-entry handshake output stage among N requesters using round-robin arbitration.
- Supports optional burst lock: a requester holding `lock` keeps the grant across consecutive beats.
- Sits in front of any single-consumer pipeline stage, e.g. several issue/commit sources feeding one downstream port.
- The output side presents the same push/full/pop/empty semantics as the team's existing handshake stages.

---
 rtl/handshake_rr_arbiter_pkg.sv | 35 +++
 rtl/handshake_rr_arbiter_dff.sv | 46 ++++
 rtl/handshake_rr_arbiter.sv | 112 +++++++++++
 tb/tb_handshake_rr_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared arbitration types and the round-robin pick helper used by the
// handshake arbiters.
package handshake_rr_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int unsigned RR_MAX_N = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] index;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... modulo n (ptr < n <= RR_MAX_N).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input int unsigned ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned i;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      if (k < n && !r.found) begin
        i = ptr + k;
        if (i >= n) i = i - n;
        if (req[i]) begin
          r.found = 1'b1;
          r.index = RR_IDX_W'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter_dff.sv
// Single-entry push/pop handshake stage; a same-cycle pop frees the slot.
module handshake_dff #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  output logic             full,
  input  logic             flush,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             pop,
  output logic             empty
);

  logic             has_data_q, has_data_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign full           = has_data_q & ~pop;
  assign data_out       = data_q;
  assign data_out_valid = has_data_q;
  assign empty          = ~has_data_q;

  always_comb begin
    has_data_d = has_data_q;
    data_d     = data_q;
    if (push && !full) begin
      has_data_d = 1'b1;
      data_d     = data_in;
    end else if (pop) begin
      has_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      has_data_q <= 1'b0;
      data_q     <= '0;
    end else begin
      has_data_q <= has_data_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter with optional burst lock feeding one shared
// single-entry handshake stage.
module handshake_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ID_WIDTH = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*WIDTH-1:0]  data_in,
  input  logic [N-1:0]        push,
  input  logic [N-1:0]        lock,
  output logic [N-1:0]        full,
  input  logic                flush,
  output logic [WIDTH-1:0]    data_out,
  output logic [ID_WIDTH-1:0] data_out_src,
  output logic                data_out_valid,
  input  logic                pop,
  output logic                empty
);
  import handshake_rr_arbiter_pkg::*;

  arb_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic [RR_MAX_N-1:0] req_ext;
  rr_pick_t            pick;
  logic [ID_WIDTH-1:0] winner;
  logic                win_valid;
  logic                stage_full;
  logic                accept;
  logic [WIDTH-1:0]    sel_data;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = push;
    pick           = rr_pick(req_ext, int'(rr_ptr_q), N);
    // A locked owner keeps the grant even while it is not pushing.
    if (state_q == ARB_LOCKED) begin
      winner    = owner_q;
      win_valid = push[owner_q];
    end else begin
      winner    = ID_WIDTH'(pick.index);
      win_valid = pick.found;
    end
  end

  always_comb begin
    accept   = win_valid & ~stage_full & ~(rst | flush);
    full     = '1;
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (winner == ID_WIDTH'(i)) begin
        full[i]  = (rst | flush) | ~(win_valid & ~stage_full);
        sel_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (winner == ID_WIDTH'(N-1)) ? '0 : winner + ID_WIDTH'(1);
      case (state_q)
        ARB_IDLE: begin
          if (lock[winner]) begin
            state_d = ARB_LOCKED;
            owner_d = winner;
          end
        end
        ARB_LOCKED: begin
          if (!lock[owner_q]) state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else if (flush) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  handshake_dff #(
    .WIDTH(WIDTH + ID_WIDTH)
  ) u_stage (
    .clk           (clk),
    .rst           (rst),
    .data_in       ({winner, sel_data}),
    .push          (|(push & ~full)),
    .full          (stage_full),
    .flush         (flush),
    .data_out      ({data_out_src, data_out}),
    .data_out_valid(data_out_valid),
    .pop           (pop),
    .empty         (empty)
  );

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter: an N=4 instance and an N=2 instance.
module tb_handshake_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=4, WIDTH=8 instance
  logic [31:0] a_din;
  logic [3:0]  a_push, a_lock, a_full;
  logic        a_flush, a_pop, a_valid, a_empty;
  logic [7:0]  a_dout;
  logic [1:0]  a_src;

  // N=2, WIDTH=8 instance
  logic [15:0] b_din;
  logic [1:0]  b_push, b_lock, b_full;
  logic        b_flush, b_pop, b_valid, b_empty;
  logic [7:0]  b_dout;
  logic        b_src;

  int n_checked  = 0;
  int n_mismatch = 0;

  handshake_rr_arbiter #(.N(4), .WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .push(a_push), .lock(a_lock),
    .full(a_full), .flush(a_flush), .data_out(a_dout), .data_out_src(a_src),
    .data_out_valid(a_valid), .pop(a_pop), .empty(a_empty)
  );

  handshake_rr_arbiter #(.N(2), .WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .push(b_push), .lock(b_lock),
    .full(b_full), .flush(b_flush), .data_out(b_dout), .data_out_src(b_src),
    .data_out_valid(b_valid), .pop(b_pop), .empty(b_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checked++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_push = 4'b0001; a_lock = '0; a_flush = 1'b0; a_pop = 1'b0;
    b_din = {8'hB1, 8'hB0};
    b_push = '0; b_lock = '0; b_flush = 1'b0; b_pop = 1'b0;

    // reset
    step(); #1;
    check("full_in_rst", a_full, 4'b1111);
    step();
    check("rst_empty", a_empty, 1);
    check("rst_valid", a_valid, 0);
    check("rst_dout", a_dout, 0);
    check("rst_src", a_src, 0);
    check("rst_b_empty", b_empty, 1);
    rst = 1'b0; #1;
    check("full_after_rst", a_full, 4'b1110);
    a_push = '0;
    step();
    check("no_accept_empty", a_empty, 1);

    // fairness, one beat per cycle
    a_push = 4'b1111; a_pop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_src", a_src, k % 4);
      check("fair_data", a_dout, 8'hA0 + k % 4);
      check("fair_valid", a_valid, 1);
    end
    a_push = '0;
    step();
    check("drain_empty", a_empty, 1);

    // backpressure (rr_ptr = 0)
    a_push = 4'b0001; a_pop = 1'b0;
    step();
    check("bp_load_src", a_src, 0);
    a_push = 4'b0100; #1;
    check("bp_full", a_full, 4'b1111);
    step();
    check("bp_hold_data", a_dout, 8'hA0);
    check("bp_hold_src", a_src, 0);
    a_pop = 1'b1; #1;
    check("bp_full_pop", a_full, 4'b1011);
    step();
    check("bp_src2", a_src, 2);
    check("bp_data2", a_dout, 8'hA2);
    a_push = '0;
    step();

    // burst lock: move rr_ptr from 3 to 1 first
    a_push = 4'b0001;
    step();
    a_push = 4'b1011; a_lock = 4'b0010; #1;
    check("lk_full_first", a_full, 4'b1101);
    step();
    check("lk_src_b1", a_src, 1);
    a_din[7:0] = 8'hC0; #1;
    check("lk_full_locked", a_full, 4'b1101);
    step();
    check("lk_src_b2", a_src, 1);
    a_lock = '0;
    step();
    check("lk_src_b3", a_src, 1);
    check("lk_data_b3", a_dout, 8'hA1);
    a_push = 4'b1001;
    step();
    check("lk_resume_src", a_src, 3);
    step();
    check("lk_wrap_src", a_src, 0);
    check("lk_wrap_data", a_dout, 8'hC0);
    a_din[7:0] = 8'hA0;

    // flush mid-burst: lock on req2 (rr_ptr = 1)
    a_push = 4'b0100; a_lock = 4'b0100;
    step();
    check("fl_locked_src", a_src, 2);
    a_push = 4'b1011; a_lock = '0; a_pop = 1'b0; #1;
    check("fl_owner_idle_full", a_full, 4'b1111);
    a_push = 4'b1111; a_pop = 1'b1; a_flush = 1'b1; #1;
    check("fl_full_flush", a_full, 4'b1111);
    step();
    check("fl_empty", a_empty, 1);
    check("fl_valid", a_valid, 0);
    check("fl_dout", a_dout, 0);
    a_flush = 1'b0; #1;
    check("fl_idle_ptr3_full", a_full, 4'b0111);
    step();
    check("fl_next_src", a_src, 3);
    a_push = '0;
    step();

    // N=2 simultaneous pop + push
    b_push = 2'b01;
    step();
    check("b_load_src", b_src, 0);
    b_push = 2'b10; b_pop = 1'b1; #1;
    check("b_full_popping", b_full, 2'b01);
    step();
    check("b_valid", b_valid, 1);
    check("b_src", b_src, 1);
    check("b_data", b_dout, 8'hB1);
    b_push = '0;
    step();
    check("b_empty", b_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_mismatch);
    $finish;
  end

endmodule
